// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - control, ROM and issue signals of the instruction sequencer
interface instruction_sequencer_if #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 17,
   parameter int ITER_WIDTH  = 8
);
   logic                   start_i;
   logic                   abort_i;
   logic [PC_WIDTH-1:0]    prog_last_i;
   logic [PC_WIDTH-1:0]    loop_start_i;
   logic [PC_WIDTH-1:0]    loop_end_i;
   logic [ITER_WIDTH-1:0]  loop_count_i;
   logic [PC_WIDTH-1:0]    rom_addr_o;
   logic [INSTR_WIDTH-1:0] rom_data_i;
   logic [INSTR_WIDTH-1:0] instruction_o;
   logic                   busy_o;
   logic                   done_o;
   logic [ITER_WIDTH-1:0]  iter_o;

   modport master (
      input  start_i, abort_i, prog_last_i, loop_start_i, loop_end_i, loop_count_i, rom_data_i,
      output rom_addr_o, instruction_o, busy_o, done_o, iter_o
   );

   modport slave (
      output start_i, abort_i, prog_last_i, loop_start_i, loop_end_i, loop_count_i, rom_data_i,
      input  rom_addr_o, instruction_o, busy_o, done_o, iter_o
   );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - microcode sequencer feeding one instruction per cycle to core_sim
// SEQ_LOOP_EN enables the single hardware loop region; without it the program runs linearly.
module instruction_sequencer #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 17,
   parameter int ITER_WIDTH  = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   instruction_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state;
   logic [PC_WIDTH-1:0]    pc;
   logic [PC_WIDTH-1:0]    last;
   logic                   fetch_valid;
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   busy;
   logic                   done;
   logic                   wrap;

`ifdef SEQ_LOOP_EN
   logic [PC_WIDTH-1:0]    lstart;
   logic [PC_WIDTH-1:0]    lend;
   logic [ITER_WIDTH-1:0]  lcount;
   logic [ITER_WIDTH-1:0]  iter;
   logic                   loop_en;

   // loop_en guarantees lcount >= 2, so lcount-1 cannot underflow
   assign wrap = loop_en && (pc == lend) && (iter < lcount - ITER_WIDTH'(1));
   assign bus.iter_o = iter;
`else
   assign wrap = 1'b0;
   assign bus.iter_o = '0;
`endif

   assign bus.rom_addr_o    = pc;
   assign bus.instruction_o = instruction;
   assign bus.busy_o        = busy;
   assign bus.done_o        = done;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         pc          <= '0;
         last        <= '0;
         fetch_valid <= 1'b0;
         instruction <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef SEQ_LOOP_EN
         lstart      <= '0;
         lend        <= '0;
         lcount      <= '0;
         iter        <= '0;
         loop_en     <= 1'b0;
`endif
      end else begin
         done        <= 1'b0;
         instruction <= fetch_valid ? bus.rom_data_i : '0;
         if (state != IDLE && bus.abort_i) begin
            // in-flight ROM data is dropped: NOP on the very next edge
            state       <= IDLE;
            pc          <= '0;
            fetch_valid <= 1'b0;
            instruction <= '0;
            busy        <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start_i && !bus.abort_i) begin
                     state <= RUN;
                     pc    <= '0;
                     last  <= bus.prog_last_i;
                     busy  <= 1'b1;
`ifdef SEQ_LOOP_EN
                     lstart  <= bus.loop_start_i;
                     lend    <= bus.loop_end_i;
                     lcount  <= bus.loop_count_i;
                     iter    <= '0;
                     loop_en <= (bus.loop_start_i <= bus.loop_end_i) &&
                                (bus.loop_end_i <= bus.prog_last_i) &&
                                (bus.loop_count_i >= ITER_WIDTH'(2));
`endif
                  end
               end
               RUN: begin
                  fetch_valid <= 1'b1;
                  if (wrap) begin
`ifdef SEQ_LOOP_EN
                     pc   <= lstart;
                     iter <= iter + ITER_WIDTH'(1);
`endif
                  end else if (pc == last) begin
                     state <= DRAIN;
                  end else begin
                     pc <= pc + PC_WIDTH'(1);
                  end
               end
               DRAIN: begin
                  // first DRAIN edge issues the final word; the second retires the run
                  fetch_valid <= 1'b0;
                  if (!fetch_valid) begin
                     state <= IDLE;
                     pc    <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench for instruction_sequencer
module tb_instruction_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [16:0] exp_q[$];

`ifdef SEQ_LOOP_EN
   localparam bit LOOP_HW = 1'b1;
`else
   localparam bit LOOP_HW = 1'b0;
`endif

   instruction_sequencer_if #(.PC_WIDTH(8), .INSTR_WIDTH(17), .ITER_WIDTH(8)) bus ();

   instruction_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(17), .ITER_WIDTH(8)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // synchronous-read ROM holding 17'h10000 | address
   always @(posedge clk) bus.rom_data_i <= {9'h100, bus.rom_addr_o};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_instr"}, 32'(bus.instruction_o), 32'h0);
      check({tag, "_busy"}, 32'(bus.busy_o), 32'h0);
      check({tag, "_done"}, 32'(bus.done_o), 32'h0);
   endtask

   // abort_at / rst_at: cycle index at which to interrupt the run (-1 for none)
   task automatic run_prog(input int last, input int ls, input int le, input int cnt,
                           input int abort_at, input int rst_at, input bit poke_start);
      int addrs[$];
      int iters[$];
      int n;
      bit lp;
      lp = LOOP_HW && (ls <= le) && (le <= last) && (cnt >= 2);
      if (!lp) begin
         for (int a = 0; a <= last; a++) begin addrs.push_back(a); iters.push_back(0); end
      end else begin
         for (int a = 0; a < ls; a++) begin addrs.push_back(a); iters.push_back(0); end
         for (int p = 0; p < cnt; p++)
            for (int a = ls; a <= le; a++) begin addrs.push_back(a); iters.push_back(p); end
         for (int a = le + 1; a <= last; a++) begin addrs.push_back(a); iters.push_back(0); end
      end
      n = addrs.size();
      exp_q.delete();
      foreach (addrs[i]) exp_q.push_back(17'h10000 | 17'(addrs[i]));

      @(negedge clk);
      bus.prog_last_i  = 8'(last);
      bus.loop_start_i = 8'(ls);
      bus.loop_end_i   = 8'(le);
      bus.loop_count_i = 8'(cnt);
      bus.start_i      = 1'b1;
      for (int c = 0; c < n + 4; c++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         if (c < n) begin
            check($sformatf("addr[%0d]", c), 32'(bus.rom_addr_o), 32'(addrs[c]));
            check($sformatf("iter[%0d]", c), 32'(bus.iter_o), LOOP_HW ? 32'(iters[c]) : 32'h0);
         end
         if (c >= 2 && c < n + 2) begin
            if (exp_q.size() == 0) check("scoreboard_empty", 32'h1, 32'h0);
            else check($sformatf("instr[%0d]", c - 2), 32'(bus.instruction_o), 32'(exp_q.pop_front()));
            check("busy_run", 32'(bus.busy_o), 32'h1);
            check("done_early", 32'(bus.done_o), 32'h0);
         end
         if (c == n + 2) begin
            check("done_pulse", 32'(bus.done_o), 32'h1);
            check("instr_nop_after", 32'(bus.instruction_o), 32'h0);
            check("busy_fall", 32'(bus.busy_o), 32'h0);
         end
         if (c == n + 3) check("done_once", 32'(bus.done_o), 32'h0);
         if (poke_start && c == 1) bus.start_i = 1'b1;
         if (c == abort_at || c == rst_at) begin
            if (c == abort_at) bus.abort_i = 1'b1;
            else rst_n = 1'b0;
            @(negedge clk);
            bus.abort_i = 1'b0;
            rst_n = 1'b1;
            check_idle(c == abort_at ? "abort" : "mid_reset");
            check("intr_addr", 32'(bus.rom_addr_o), 32'h0);
            check("intr_iter", 32'(bus.iter_o), 32'h0);
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check_idle("after_intr");
            end
            exp_q.delete();
            return;
         end
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.start_i      = 1'b1;
      bus.abort_i      = 1'b0;
      bus.prog_last_i  = 8'd4;
      bus.loop_start_i = 8'd0;
      bus.loop_end_i   = 8'd0;
      bus.loop_count_i = 8'd0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("reset_addr", 32'(bus.rom_addr_o), 32'h0);
      check("reset_iter", 32'(bus.iter_o), 32'h0);
      bus.start_i = 1'b0;
      rst_n       = 1'b1;
      @(negedge clk);

      run_prog(4, 0, 0, 0, -1, -1, 1'b0);
      run_prog(9, 3, 5, 3, -1, -1, 1'b0);
      run_prog(9, 3, 5, 3, 2, -1, 1'b0);
      run_prog(4, 0, 0, 0, -1, -1, 1'b0);
      run_prog(0, 0, 0, 0, -1, -1, 1'b1);
      run_prog(9, 3, 5, 3, -1, 7, 1'b0);
      run_prog(6, 5, 2, 4, -1, -1, 1'b0);
      run_prog(7, 2, 2, 1, -1, -1, 1'b0);
      run_prog(255, 250, 255, 2, -1, -1, 1'b0);

      // abort and start together in IDLE: abort wins
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      check("abort_start_busy", 32'(bus.busy_o), 32'h0);
      @(negedge clk);
      check("abort_start_instr", 32'(bus.instruction_o), 32'h0);

      run_prog(2, 0, 0, 0, -1, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
